// File: rtl/ks_string_voice.sv
// Karplus-Strong plucked-string voice.
// A pluck fills a circular delay buffer of L words with LFSR noise (LOAD),
// then each sample strobe reads one word, outputs it and writes back the
// two-tap average of it and the previous sample, optionally decayed (PLAY).
//
// Handshake: out_valid is a single-cycle qualifier for out. It is raised on
// the clk edge that samples an accepted sample_en (latency 1 clk) and there
// is no back-pressure; out holds its value until the next accepted sample
// or until the note stops, when it returns to 0.
module ks_string_voice #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int DECAY_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              pluck,
  input  logic              mute,
  input  logic [ADDR_W-1:0] len_m1,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  localparam int MAX_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic [ADDR_W-1:0]         r_lm1;    // loop length minus one, never below 1
  logic [ADDR_W-1:0]         r_idx;    // write index during LOAD
  logic [ADDR_W-1:0]         r_rd;     // read/write-back pointer during PLAY
  logic signed [WIDTH-1:0]   r_prev;
  logic [15:0]               r_lfsr;
  logic [WIDTH-1:0]          r_out;
  logic                      r_valid;
  logic [WIDTH-1:0]          r_buf [0:MAX_DEPTH-1];

  logic                      w_accept;
  logic                      w_load;
  logic                      w_step;
  logic [ADDR_W-1:0]         w_len_lm1;
  logic [15:0]               w_lfsr_next;
  logic signed [WIDTH-1:0]   w_x;
  logic signed [WIDTH:0]     w_sum;
  logic signed [WIDTH-1:0]   w_a;
  logic signed [WIDTH-1:0]   w_dec;
  logic                      w_we;
  logic [ADDR_W-1:0]         w_waddr;
  logic [WIDTH-1:0]          w_wdata;

  // Loop length of 1 would make the filter degenerate, so clamp to 2.
  assign w_len_lm1   = (len_m1 == '0) ? ADDR_W'(1) : len_m1;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Averaging filter: sum in WIDTH+1 bits so it cannot wrap, then halve.
  assign w_x   = r_buf[r_rd];
  assign w_sum = $signed({w_x[WIDTH-1], w_x}) + $signed({r_prev[WIDTH-1], r_prev});
  assign w_a   = WIDTH'(w_sum >>> 1);

  generate
    if (DECAY_SHIFT > 0) begin : g_decay
      assign w_dec = w_a - (w_a >>> DECAY_SHIFT);
    end else begin : g_no_decay
      assign w_dec = w_a;
    end
  endgenerate

  // Single write port shared by the noise fill and the filter write-back.
  assign w_we    = w_load | w_step;
  assign w_waddr = w_load ? r_idx : r_rd;
  assign w_wdata = w_load ? r_lfsr[WIDTH-1:0] : w_dec;

  assign out         = r_out;
  assign out_valid   = r_valid;
  assign busy        = (r_state == S_LOAD);
  assign o_dbg_state = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state: mute overrides everything, pluck is deaf during LOAD.
  always_comb begin
    w_next = r_state;
    if (mute) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (pluck) w_next = S_LOAD;
        S_LOAD:  if (r_idx == r_lm1) w_next = S_PLAY;
        S_PLAY:  if (pluck) w_next = S_LOAD;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: control strobes for the datapath; pluck beats sample_en.
  always_comb begin
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    if (!mute) begin
      w_accept = pluck && (r_state != S_LOAD);
      w_load   = (r_state == S_LOAD);
      w_step   = sample_en && !pluck && (r_state == S_PLAY);
    end
  end

  // Datapath registers: note setup, noise fill, playback and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lm1   <= ADDR_W'(1);
      r_idx   <= '0;
      r_rd    <= '0;
      r_prev  <= '0;
      r_lfsr  <= 16'hACE1;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_step;
      if (w_accept) begin
        r_lm1  <= w_len_lm1;
        r_idx  <= '0;
        r_rd   <= '0;
        r_prev <= '0;
      end
      if (w_load) begin
        r_lfsr <= w_lfsr_next;
        r_idx  <= r_idx + ADDR_W'(1);
        if (r_idx == r_lm1) r_rd <= '0;
      end
      if (w_step) begin
        r_out  <= w_x;
        r_prev <= w_x;
        r_rd   <= (r_rd == r_lm1) ? '0 : r_rd + ADDR_W'(1);
      end else if (w_next != S_PLAY) begin
        r_out <= '0;
      end
    end
  end

  // Delay buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_wdata;
  end

endmodule
